legup_mult_accum: RTL and testbench

- Streaming accumulator directly downstream of the combinational multiplier core.
- Consumes product words through a valid/ready handshake and sums them into a wide accumulator.
- Emits one sum per group of products, where a group is terminated by in_last.
- Used for dot-product and MAC loops in generated datapaths; the registered output cuts the path after the multiplier.

---
 rtl/legup_mult_accum.sv | 144 ++++++++++++++
 tb/tb_legup_mult_accum.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/legup_mult_accum.sv
// rtl/legup_mult_accum.sv - streaming product accumulator with per-group registered result
module legup_mult_accum #(
    parameter int    widthp         = 64,
    parameter int    widthacc       = 80,
    parameter string representation = "UNSIGNED"
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [widthp-1:0]   in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [widthacc-1:0] out_data,
    output logic [15:0]         out_count,
    output logic                out_overflow
);

    localparam bit is_signed = (representation != "UNSIGNED");

    generate
        if (widthacc < widthp) begin : g_width_check
            $error("legup_mult_accum: widthacc must be >= widthp");
        end
    endgenerate

    typedef enum logic [0:0] {IDLE, ACCUM} state_t;

    state_t                state_q, state_d;
    logic [widthacc-1:0]   acc_q, acc_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  out_valid_q, out_valid_d;
    logic [widthacc-1:0]   out_data_q, out_data_d;
    logic [15:0]           out_count_q, out_count_d;
    logic                  out_ovf_q, out_ovf_d;

    logic [widthacc-1:0]   ext;
    logic [widthacc:0]     sum_full;
    logic [widthacc-1:0]   sum;
    logic                  ovf_now;
    logic [15:0]           cnt_inc;
    logic                  in_fire;
    logic                  sign_bit;

    assign sign_bit = is_signed ? in_data[widthp-1] : 1'b0;

    generate
        if (widthacc > widthp) begin : g_ext
            assign ext = {{(widthacc-widthp){sign_bit}}, in_data};
        end else begin : g_noext
            assign ext = in_data;
        end
    endgenerate

    assign sum_full = {1'b0, acc_q} + {1'b0, ext};
    assign sum      = sum_full[widthacc-1:0];
    // Signed overflow: operands agree in sign but the result does not.
    assign ovf_now  = is_signed
                    ? ((acc_q[widthacc-1] == ext[widthacc-1]) && (sum[widthacc-1] != acc_q[widthacc-1]))
                    : sum_full[widthacc];
    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    assign in_ready = !out_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_fire) begin
            case (state_q)
                IDLE: begin
                    if (in_last) begin
                        out_valid_d = 1'b1;
                        out_data_d  = ext;
                        out_count_d = 16'd1;
                        out_ovf_d   = 1'b0;
                    end else begin
                        state_d = ACCUM;
                        acc_d   = ext;
                        cnt_d   = 16'd1;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    if (in_last) begin
                        out_valid_d = 1'b1;
                        out_data_d  = sum;
                        out_count_d = cnt_inc;
                        out_ovf_d   = ovf_q | ovf_now;
                        state_d     = IDLE;
                        acc_d       = '0;
                        cnt_d       = 16'd0;
                        ovf_d       = 1'b0;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | ovf_now;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= 16'd0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= 16'd0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_count    = out_count_q;
    assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_legup_mult_accum.sv
// tb/tb_legup_mult_accum.sv - directed table-driven checks of legup_mult_accum in three configurations
module tb_legup_mult_accum;

    logic        clock = 1'b0;
    logic        reset;
    logic        iv   [3];
    logic        il   [3];
    logic [63:0] idat [3];
    logic        ordy [3];
    logic        ir   [3];
    logic        ov   [3];
    logic [15:0] oc   [3];
    logic        oo   [3];
    logic [79:0] od_u80, od_s80;
    logic [63:0] od_u64;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clock = ~clock;

    legup_mult_accum #(.widthp(64), .widthacc(80), .representation("UNSIGNED")) u_u80 (
        .clock(clock), .reset(reset),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]), .in_last(il[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od_u80),
        .out_count(oc[0]), .out_overflow(oo[0])
    );

    legup_mult_accum #(.widthp(64), .widthacc(80), .representation("SIGNED")) u_s80 (
        .clock(clock), .reset(reset),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]), .in_last(il[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od_s80),
        .out_count(oc[1]), .out_overflow(oo[1])
    );

    legup_mult_accum #(.widthp(64), .widthacc(64), .representation("UNSIGNED")) u_u64 (
        .clock(clock), .reset(reset),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idat[2]), .in_last(il[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od_u64),
        .out_count(oc[2]), .out_overflow(oo[2])
    );

    typedef struct {
        int          sel;
        logic [63:0] data;
        logic        last;
        int          mode;   // 1: expect no result yet, 2: expect full result
        logic [79:0] ed;
        logic [15:0] ec;
        logic        eo;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [79:0] get_data(int sel);
        case (sel)
            0:       return od_u80;
            1:       return od_s80;
            default: return {16'd0, od_u64};
        endcase
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_result(input string name, input int sel, input logic [79:0] ed,
                              input logic [15:0] ec, input logic eo);
        chk({name, ".valid"}, {79'd0, ov[sel]}, 80'd1);
        chk({name, ".data"},  get_data(sel), ed);
        chk({name, ".count"}, {64'd0, oc[sel]}, {64'd0, ec});
        chk({name, ".ovf"},   {79'd0, oo[sel]}, {79'd0, eo});
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            il[k]   = 1'b0;
            idat[k] = 64'd0;
        end
    endtask

    initial begin
        tbl[0]  = '{0, 64'd3,  1'b0, 1, 80'd0,  16'd0, 1'b0};
        tbl[1]  = '{0, 64'd5,  1'b0, 1, 80'd0,  16'd0, 1'b0};
        tbl[2]  = '{0, 64'd7,  1'b1, 2, 80'd15, 16'd3, 1'b0};
        tbl[3]  = '{0, 64'd42, 1'b1, 2, 80'd42, 16'd1, 1'b0};
        tbl[4]  = '{0, 64'd43, 1'b1, 2, 80'd43, 16'd1, 1'b0};
        tbl[5]  = '{0, 64'd44, 1'b1, 2, 80'd44, 16'd1, 1'b0};
        tbl[6]  = '{1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1, 80'd0, 16'd0, 1'b0};
        tbl[7]  = '{1, 64'd10, 1'b0, 1, 80'd0,  16'd0, 1'b0};
        tbl[8]  = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2, 80'd5, 16'd3, 1'b0};
        tbl[9]  = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1, 80'd0, 16'd0, 1'b0};
        tbl[10] = '{2, 64'd2,  1'b1, 2, 80'd1,  16'd2, 1'b1};
        tbl[11] = '{2, 64'd1,  1'b1, 2, 80'd1,  16'd1, 1'b0};

        clear_inputs();
        for (int k = 0; k < 3; k++) ordy[k] = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset%0d.valid", k), {79'd0, ov[k]}, 80'd0);
            chk($sformatf("reset%0d.data", k),  get_data(k), 80'd0);
            chk($sformatf("reset%0d.count", k), {64'd0, oc[k]}, 80'd0);
            chk($sformatf("reset%0d.ovf", k),   {79'd0, oo[k]}, 80'd0);
            chk($sformatf("reset%0d.in_ready", k), {79'd0, ir[k]}, 80'd1);
        end
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 12; i++) begin
            clear_inputs();
            iv[tbl[i].sel]   = 1'b1;
            idat[tbl[i].sel] = tbl[i].data;
            il[tbl[i].sel]   = tbl[i].last;
            @(posedge clock);
            #1;
            clear_inputs();
            if (tbl[i].mode == 1)
                chk($sformatf("vec%0d.valid", i), {79'd0, ov[tbl[i].sel]}, 80'd0);
            else
                chk_result($sformatf("vec%0d", i), tbl[i].sel, tbl[i].ed, tbl[i].ec, tbl[i].eo);
        end
        @(posedge clock);
        #1;
        chk("drain.valid", {79'd0, ov[0]}, 80'd0);

        // Backpressure: group A (4+5) held while group B's single beat waits
        ordy[0] = 1'b0;
        iv[0] = 1'b1; idat[0] = 64'd4; il[0] = 1'b0;
        @(posedge clock); #1;
        idat[0] = 64'd5; il[0] = 1'b1;
        @(posedge clock); #1;
        chk_result("bpA", 0, 80'd9, 16'd2, 1'b0);
        idat[0] = 64'd6; il[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_stall%0d.in_ready", c), {79'd0, ir[0]}, 80'd0);
            @(posedge clock); #1;
            chk_result($sformatf("bp_stall%0d", c), 0, 80'd9, 16'd2, 1'b0);
        end
        ordy[0] = 1'b1;
        #1;
        chk("bpB.in_ready", {79'd0, ir[0]}, 80'd1);
        @(posedge clock); #1;
        clear_inputs();
        chk_result("bpB", 0, 80'd6, 16'd1, 1'b0);
        @(posedge clock); #1;
        chk("bpB.drain", {79'd0, ov[0]}, 80'd0);

        // Reset mid-group drops the partial sum
        iv[0] = 1'b1; idat[0] = 64'd8; il[0] = 1'b0;
        @(posedge clock); #1;
        idat[0] = 64'd12;
        @(posedge clock); #1;
        clear_inputs();
        reset = 1'b1;
        #1;
        chk("rst_mid.valid", {79'd0, ov[0]}, 80'd0);
        chk("rst_mid.data",  od_u80, 80'd0);
        chk("rst_mid.count", {64'd0, oc[0]}, 80'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        iv[0] = 1'b1; idat[0] = 64'd1; il[0] = 1'b1;
        @(posedge clock); #1;
        clear_inputs();
        chk_result("rst_after", 0, 80'd1, 16'd1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
